// File: rtl/count_ctrl.sv
// Programmable interval timer: run-control FSM around a WIDTH-bit down-counter
// with one-shot/auto-reload, pause/resume, abort and a clock prescaler.
module count_ctrl #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             mode_reload,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             paused,
    output logic             done,
    output logic             expire
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             mode_q, mode_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic             expire_q, expire_d;
    logic             busy_q, paused_q, done_q;
    logic             tick;
    logic             expiring;

    assign tick     = (pre_q == PW'(PRESCALE - 1));
    assign expiring = tick && (count_q == WIDTH'(1));

    // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        mode_d   = mode_q;
        pre_d    = pre_q;
        expire_d = 1'b0;

        if (stop) begin
            state_d = IDLE;
            count_d = '0;
            pre_d   = '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start && load_val != '0) begin
                        state_d  = RUN;
                        count_d  = load_val;
                        reload_d = load_val;
                        mode_d   = mode_reload;
                        pre_d    = '0;
                    end
                end
                RUN, HOLD: begin
                    // An expiring tick in RUN beats pause; otherwise pause freezes everything.
                    if (pause && !(state_q == RUN && expiring)) begin
                        state_d = HOLD;
                    end else begin
                        pre_d   = tick ? '0 : pre_q + PW'(1);
                        state_d = pause ? HOLD : RUN;
                        if (tick) begin
                            if (expiring) begin
                                expire_d = 1'b1;
                                if (mode_q) begin
                                    count_d = reload_q;
                                end else begin
                                    count_d = '0;
                                    state_d = DONE;
                                end
                            end else begin
                                count_d = count_q - WIDTH'(1);
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            mode_q   <= 1'b0;
            pre_q    <= '0;
            expire_q <= 1'b0;
            busy_q   <= 1'b0;
            paused_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            mode_q   <= mode_d;
            pre_q    <= pre_d;
            expire_q <= expire_d;
            busy_q   <= (state_d == RUN) || (state_d == HOLD);
            paused_q <= (state_d == HOLD);
            done_q   <= (state_d == DONE);
        end
    end

    assign count  = count_q;
    assign busy   = busy_q;
    assign paused = paused_q;
    assign done   = done_q;
    assign expire = expire_q;

endmodule

// File: tb/tb_count_ctrl.sv
// Bench for count_ctrl: two instances (PRESCALE 1 and 3) share stimulus; a per-cycle
// reference model feeds scoreboard queues, plus directed checks of the key timings.
module tb_count_ctrl;

    localparam int W = 4;
    localparam int S_IDLE = 0, S_RUN = 1, S_HOLD = 2, S_DONE = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0, stop = 1'b0, pause = 1'b0, mode_reload = 1'b0;
    logic [W-1:0] load_val = '0;

    logic [W-1:0] count1, count3;
    logic         busy1, paused1, done1, expire1;
    logic         busy3, paused3, done3, expire3;

    always #5 clk = ~clk;

    count_ctrl #(.WIDTH(W), .PRESCALE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
        .mode_reload(mode_reload), .load_val(load_val), .count(count1),
        .busy(busy1), .paused(paused1), .done(done1), .expire(expire1));

    count_ctrl #(.WIDTH(W), .PRESCALE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
        .mode_reload(mode_reload), .load_val(load_val), .count(count3),
        .busy(busy3), .paused(paused3), .done(done3), .expire(expire3));

    typedef struct {
        int st;
        int cnt;
        int rld;
        bit mode;
        int pre;
        bit exp;
    } mdl_t;

    mdl_t m1, m3;
    int   q1[$];
    int   q3[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.st = S_IDLE; m.cnt = 0; m.rld = 0; m.mode = 1'b0; m.pre = 0; m.exp = 1'b0;
        return m;
    endfunction

    function automatic mdl_t mdl_next(input mdl_t m, input int ps, input bit st_i,
                                      input bit sp_i, input bit pa_i, input bit mr_i,
                                      input int lv_i);
        mdl_t n;
        bit   tk;
        bit   fire;
        n     = m;
        n.exp = 1'b0;
        if (sp_i) begin
            n.st = S_IDLE; n.cnt = 0; n.pre = 0;
            return n;
        end
        if (m.st == S_IDLE || m.st == S_DONE) begin
            if (st_i && lv_i != 0) begin
                n.st = S_RUN; n.cnt = lv_i; n.rld = lv_i; n.mode = mr_i; n.pre = 0;
            end
            return n;
        end
        tk   = (m.pre == ps - 1);
        fire = tk && (m.cnt == 1);
        if (pa_i && !(m.st == S_RUN && fire)) begin
            n.st = S_HOLD;
            return n;
        end
        n.pre = tk ? 0 : m.pre + 1;
        n.st  = pa_i ? S_HOLD : S_RUN;
        if (fire) begin
            n.exp = 1'b1;
            if (m.mode) n.cnt = m.rld;
            else begin
                n.cnt = 0;
                n.st  = S_DONE;
            end
        end else if (tk) begin
            n.cnt = m.cnt - 1;
        end
        return n;
    endfunction

    function automatic int pack(input int c, input bit b, input bit p, input bit d, input bit e);
        return (c << 4) | (int'(b) << 3) | (int'(p) << 2) | (int'(d) << 1) | int'(e);
    endfunction

    function automatic int mdl_out(input mdl_t m);
        return pack(m.cnt, m.st == S_RUN || m.st == S_HOLD, m.st == S_HOLD, m.st == S_DONE, m.exp);
    endfunction

    // Reference model advances on each active edge and queues the outputs it predicts.
    always @(posedge clk) begin
        if (!rst_n) begin
            m1 = mdl_reset();
            m3 = mdl_reset();
        end else begin
            m1 = mdl_next(m1, 1, start, stop, pause, mode_reload, int'(load_val));
            m3 = mdl_next(m3, 3, start, stop, pause, mode_reload, int'(load_val));
        end
        q1.push_back(mdl_out(m1));
        q3.push_back(mdl_out(m3));
    end

    always @(negedge clk) begin
        if (q1.size() > 0)
            check("sb_ps1", pack(int'(count1), busy1, paused1, done1, expire1), q1.pop_front());
        if (q3.size() > 0)
            check("sb_ps3", pack(int'(count3), busy3, paused3, done3, expire3), q3.pop_front());
    end

    task automatic pulse_start(input int lv, input bit mr);
        start       = 1'b1;
        load_val    = W'(lv);
        mode_reload = mr;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    initial begin
        int n_exp;
        int n;

        repeat (3) @(negedge clk);
        check("rst_count", count1, 0);
        check("rst_busy", busy1, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // One-shot, load 5
        pulse_start(5, 1'b0);
        check("os_load", count1, 5);
        repeat (5) @(negedge clk);
        check("os_expire", expire1, 1);
        check("os_count0", count1, 0);
        check("os_done", done1, 1);
        check("os_busy", busy1, 0);
        @(negedge clk);
        check("os_exp_1cyc", expire1, 0);
        check("os_hold0", count1, 0);

        // Auto-reload, load 3
        pulse_start(3, 1'b1);
        n_exp = 0;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            check("rl_seq", count1, 3 - (i % 3));
            n_exp += int'(expire1);
        end
        check("rl_nexp", n_exp, 3);
        pulse_stop();
        check("rl_stop_cnt", count1, 0);
        check("rl_stop_busy", busy1, 0);
        n_exp = 0;
        repeat (6) begin
            @(negedge clk);
            n_exp += int'(expire1);
        end
        check("rl_no_exp", n_exp, 0);

        // Pause for 3 cycles at count 4
        pulse_start(6, 1'b0);
        repeat (2) @(negedge clk);
        check("ps_at4", count1, 4);
        pause = 1'b1;
        @(negedge clk);
        check("ps_paused", paused1, 1);
        check("ps_frozen", count1, 4);
        repeat (2) @(negedge clk);
        check("ps_frozen2", count1, 4);
        pause = 1'b0;
        @(negedge clk);
        check("ps_resume", count1, 3);
        check("ps_unpaused", paused1, 0);
        repeat (2) @(negedge clk);
        check("ps_noexp_yet", expire1, 0);
        @(negedge clk);
        check("ps_exp_late3", expire1, 1);

        // start+stop together, zero load, restart while running
        start = 1'b1; stop = 1'b1; load_val = W'(7);
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        check("ss_busy", busy1, 0);
        check("ss_done", done1, 0);
        check("ss_busy3", busy3, 0);
        pulse_start(0, 1'b0);
        check("z_ignored", busy1, 0);
        pulse_start(8, 1'b1);
        check("rs_load", count1, 8);
        pulse_start(9, 1'b0);
        check("rs_ignored", count1, 7);
        pulse_stop();

        // Pause rising on the expiring edge of a reload run
        pulse_start(2, 1'b1);
        @(negedge clk);
        check("pe_at1", count1, 1);
        pause = 1'b1;
        @(negedge clk);
        check("pe_expire", expire1, 1);
        check("pe_paused", paused1, 1);
        check("pe_reload", count1, 2);
        @(negedge clk);
        check("pe_no_exp", expire1, 0);
        pause = 1'b0;
        pulse_stop();

        // Prescaler 3, load 2 one-shot
        pulse_start(2, 1'b0);
        check("p3_load", count3, 2);
        repeat (2) @(negedge clk);
        check("p3_c2", count3, 2);
        @(negedge clk);
        check("p3_c3", count3, 1);
        repeat (2) @(negedge clk);
        check("p3_c5", count3, 1);
        check("p3_c5_exp", expire3, 0);
        @(negedge clk);
        check("p3_c6", count3, 0);
        check("p3_c6_exp", expire3, 1);
        check("p3_done", done3, 1);

        // Prescaler 3, max load: expiry exactly 45 cycles after start
        pulse_start(15, 1'b0);
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (expire3) break;
        end
        check("p3_period45", n, 45);
        pulse_stop();

        // Asynchronous reset mid-count
        pulse_start(9, 1'b0);
        repeat (2) @(negedge clk);
        check("ar_at7", count1, 7);
        #2 rst_n = 1'b0;
        #1;
        check("ar_count", count1, 0);
        check("ar_busy", busy1, 0);
        check("ar_exp", expire1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("ar_idle", busy1, 0);
        check("ar_idle_cnt", count1, 0);
        pulse_start(3, 1'b0);
        check("ar_restart", busy1, 1);
        check("ar_restart_cnt", count1, 3);
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
